// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM states, access-size encodings and load/store data helpers for lsu_mem_port
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_8B = 2'd0;
  localparam logic [1:0] SZ_4B = 2'd1;
  localparam logic [1:0] SZ_2B = 2'd2;
  localparam logic [1:0] SZ_1B = 2'd3;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_8B:   size_mask = 8'hFF;
      SZ_4B:   size_mask = 8'h0F;
      SZ_2B:   size_mask = 8'h03;
      default: size_mask = 8'h01;
    endcase
  endfunction

  // 8B loads pass through untouched, so the sign bit has no effect there.
  function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                         input logic sign);
    case (size)
      SZ_8B:   extend = data;
      SZ_4B:   extend = {{32{sign & data[31]}}, data[31:0]};
      SZ_2B:   extend = {{48{sign & data[15]}}, data[15:0]};
      default: extend = {{56{sign & data[7]}}, data[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane alignment: store data/mask shifted into a two-word window,
// load data shifted down from the two-word read buffer and extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0]   off_i,
  input  logic [1:0]         size_i,
  input  logic               sign_i,
  input  logic [XLEN-1:0]    wdata_i,
  input  logic [2*XLEN-1:0]  rbuf_i,
  output logic [2*XLEN-1:0]  wdata_o,
  output logic [2*BYTES-1:0] wmask_o,
  output logic [XLEN-1:0]    rdata_o
);

  logic [1:0]       size_eff;
  logic [7:0]       smask;
  logic [OFF_W+2:0] bit_off;
  logic [XLEN-1:0]  rshift;
  logic [63:0]      rext;

  always_comb begin
    // A 32-bit port has no 8-byte access; fold it onto a full-word access.
    size_eff = ((XLEN == 32) && (size_i == SZ_8B)) ? SZ_4B : size_i;
    smask    = size_mask(size_eff);
    bit_off  = {off_i, 3'b000};
    wdata_o  = {{XLEN{1'b0}}, wdata_i} << bit_off;
    wmask_o  = {{BYTES{1'b0}}, smask[BYTES-1:0]} << off_i;
    rshift   = XLEN'(rbuf_i >> bit_off);
    rext     = extend(64'(rshift), size_eff, sign_i);
    rdata_o  = rext[XLEN-1:0];
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - multi-cycle load/store port onto a request/grant memory bus.
// LSU_MISALIGN_EN: split word-crossing accesses into two beats; otherwise reject them with resp_err.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [BYTES-1:0]  mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          op_q, op_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                beat_q, beat_d;
  logic [2*XLEN-1:0]   buf_q, buf_d;

  logic [2*XLEN-1:0]   wide_wdata;
  logic [2*BYTES-1:0]  wide_mask;
  logic [XLEN-1:0]     ld_data;
  logic                two_beat;
  logic                misalign_err;
  logic [ADDR_W-1:0]   beat_base;

  lsu_align #(.XLEN(XLEN)) u_align (
    .off_i   (addr_q[OFF_W-1:0]),
    .size_i  (op_q[1:0]),
    .sign_i  (op_q[2]),
    .wdata_i (wdata_q),
    .rbuf_i  (buf_q),
    .wdata_o (wide_wdata),
    .wmask_o (wide_mask),
    .rdata_o (ld_data)
  );

  assign two_beat  = |wide_mask[2*BYTES-1:BYTES];
  assign beat_base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef LSU_MISALIGN_EN
  assign misalign_err = 1'b0;
`else
  assign misalign_err = two_beat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      beat_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = REQ;
          addr_d  = req_addr;
          op_d    = req_op;
          we_d    = req_we;
          wdata_d = req_wdata;
          beat_d  = 1'b0;
        end
      end
      REQ: begin
        // A rejected crossing access passes through REQ without raising mem_req.
        if (misalign_err) state_d = RESP;
        else if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (beat_q) buf_d[2*XLEN-1:XLEN] = mem_rdata;
          else        buf_d[XLEN-1:0]      = mem_rdata;
          if (two_beat && !beat_q) begin
            state_d = REQ;
            beat_d  = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output decodes from state and registered request data only.
  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_req    = (state_q == REQ) && !misalign_err;
    mem_we     = mem_req & we_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    if (mem_req) begin
      mem_addr  = beat_q ? (beat_base + ADDR_W'(BYTES)) : beat_base;
      mem_wdata = beat_q ? wide_wdata[2*XLEN-1:XLEN] : wide_wdata[XLEN-1:0];
      mem_wmask = beat_q ? wide_mask[2*BYTES-1:BYTES] : wide_mask[BYTES-1:0];
    end
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid & misalign_err;
    resp_rdata = (resp_valid && !we_q && !misalign_err) ? ld_data : '0;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed vector bench for lsu_mem_port with a grant/rvalid memory responder
`timescale 1ns/1ps
module tb_lsu_mem_port;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 32;
  localparam int BYTES  = XLEN / 8;
  localparam int NV     = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [2:0]        req_op = '0;
  logic              req_we = 1'b0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_gnt = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [BYTES-1:0]  mem_wmask;
  logic              mem_rvalid = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;

  lsu_mem_port #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  mask;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  op;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] word;
    logic [31:0] exp_addr;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] mem_words [logic [31:0]];
  beat_t       beats[$];
  beat_t       beat_rec;
  int          gnt_delay = 0;
  int          gcnt = 0;
  int          req_seen = 0;
  logic        rv_block = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  vec_t        vecs[NV];

  // Memory responder: grants after gnt_delay REQ cycles, completes the beat one cycle later.
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (pend && !rv_block) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_words.exists(pend_addr) ? mem_words[pend_addr] : 64'h0;
      pend       = 1'b0;
    end
    if (mem_req) begin
      req_seen++;
      if (gcnt < gnt_delay) begin
        gcnt++;
      end else begin
        gcnt           = 0;
        mem_gnt        = 1'b1;
        beat_rec.addr  = mem_addr;
        beat_rec.mask  = mem_wmask;
        beat_rec.we    = mem_we;
        beat_rec.wdata = mem_wdata;
        beats.push_back(beat_rec);
        pend      = 1'b1;
        pend_addr = mem_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] op, input logic we,
                      input logic [63:0] wd);
    req_valid = 1'b1;
    req_addr  = a;
    req_op    = op;
    req_we    = we;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    mem_words[v.exp_addr] = v.word;
    beats.delete();
    send(v.addr, v.op, v.we, v.wdata);
    wait_resp(1, lat);
    chk({v.name, " latency"}, 64'(lat), 64'd3);
    chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, " err"}, 64'(resp_err), 64'd0);
    chk({v.name, " req_ready in RESP"}, 64'(req_ready), 64'd0);
    chk({v.name, " beats"}, 64'(beats.size()), 64'd1);
    if (beats.size() > 0) begin
      chk({v.name, " addr"}, 64'(beats[0].addr), 64'(v.exp_addr));
      chk({v.name, " mask"}, 64'(beats[0].mask), 64'(v.exp_mask));
      chk({v.name, " we"}, 64'(beats[0].we), 64'(v.we));
      chk({v.name, " wdata"}, beats[0].wdata, v.exp_wdata);
    end
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{"ld4s",    32'h1004, 3'b101, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 32'h1000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321};
    vecs[1]  = '{"ld4u",    32'h1004, 3'b001, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 32'h1000, 8'hF0, 64'h0, 64'h0000_0000_8765_4321};
    vecs[2]  = '{"ld1u",    32'h3003, 3'b011, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 32'h3000, 8'h08, 64'h0, 64'h0000_0000_0000_0080};
    vecs[3]  = '{"ld1s",    32'h3003, 3'b111, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 32'h3000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[4]  = '{"ld2s_hi", 32'h4006, 3'b110, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h4000, 8'hC0, 64'h0, 64'h0000_0000_0000_1234};
    vecs[5]  = '{"ld2s_lo", 32'h4002, 3'b110, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h4000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_9ABC};
    vecs[6]  = '{"ld8",     32'h4000, 3'b100, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h4000, 8'hFF, 64'h0, 64'h1234_5678_9ABC_DEF0};
    vecs[7]  = '{"ld2u",    32'h4002, 3'b010, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h4000, 8'h0C, 64'h0, 64'h0000_0000_0000_9ABC};
    vecs[8]  = '{"ld1u_b0", 32'h4000, 3'b011, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h4000, 8'h01, 64'h0, 64'h0000_0000_0000_00F0};
    vecs[9]  = '{"st4",     32'h5004, 3'b001, 1'b1, 64'h0000_0000_DEAD_BEEF, 64'h0, 32'h5000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0};
    vecs[10] = '{"st1",     32'h5007, 3'b011, 1'b1, 64'h0000_0000_0000_00A5, 64'h0, 32'h5000, 8'h80, 64'hA500_0000_0000_0000, 64'h0};
    vecs[11] = '{"st8",     32'h5008, 3'b000, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0, 32'h5008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};

    repeat (2) @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset mem_wmask", 64'(mem_wmask), 64'd0);
    chk("reset mem_wdata", mem_wdata, 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_err", 64'(resp_err), 64'd0);
    chk("reset resp_rdata", resp_rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Word-crossing 2B store of 0xBEEF at 0x2007.
    beats.delete();
    req_seen = 0;
    send(32'h2007, 3'b010, 1'b1, 64'h0000_0000_0000_BEEF);
    wait_resp(1, lat);
`ifdef LSU_MISALIGN_EN
    chk("xst latency", 64'(lat), 64'd5);
    chk("xst beats", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      chk("xst b0 addr", 64'(beats[0].addr), 64'h2000);
      chk("xst b0 mask", 64'(beats[0].mask), 64'h80);
      chk("xst b0 wdata", beats[0].wdata, 64'hEF00_0000_0000_0000);
      chk("xst b1 addr", 64'(beats[1].addr), 64'h2008);
      chk("xst b1 mask", 64'(beats[1].mask), 64'h01);
      chk("xst b1 wdata", beats[1].wdata, 64'h0000_0000_0000_00BE);
      chk("xst b1 we", 64'(beats[1].we), 64'd1);
    end
    chk("xst err", 64'(resp_err), 64'd0);
`else
    chk("xst latency", 64'(lat), 64'd2);
    chk("xst err", 64'(resp_err), 64'd1);
    chk("xst mem_req cycles", 64'(req_seen), 64'd0);
`endif
    chk("xst rdata", resp_rdata, 64'd0);
    ack();

    // Word-crossing signed 4B load at 0x1006.
    mem_words[32'h1000] = 64'h8765_4321_0000_0000;
    mem_words[32'h1008] = 64'h0000_0000_0000_A1B2;
    beats.delete();
    req_seen = 0;
    send(32'h1006, 3'b101, 1'b0, 64'h0);
    wait_resp(1, lat);
`ifdef LSU_MISALIGN_EN
    chk("xld latency", 64'(lat), 64'd5);
    chk("xld rdata", resp_rdata, 64'hFFFF_FFFF_A1B2_8765);
    chk("xld beats", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      chk("xld b0 mask", 64'(beats[0].mask), 64'hC0);
      chk("xld b1 addr", 64'(beats[1].addr), 64'h1008);
      chk("xld b1 mask", 64'(beats[1].mask), 64'h03);
    end
`else
    chk("xld latency", 64'(lat), 64'd2);
    chk("xld err", 64'(resp_err), 64'd1);
    chk("xld rdata", resp_rdata, 64'd0);
    chk("xld mem_req cycles", 64'(req_seen), 64'd0);
`endif
    ack();

    // Grant withheld 5 cycles, then resp_ready held low 3 cycles.
    gnt_delay = 5;
    send(32'h1004, 3'b101, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      chk("gwait mem_req", 64'(mem_req), 64'd1);
      chk("gwait mem_addr", 64'(mem_addr), 64'h1000);
      chk("gwait mem_wmask", 64'(mem_wmask), 64'hF0);
      chk("gwait mem_we", 64'(mem_we), 64'd0);
      chk("gwait req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    wait_resp(6, lat);
    gnt_delay = 0;
    chk("gwait latency", 64'(lat), 64'd8);
    for (int i = 0; i < 3; i++) begin
      chk("hold resp_valid", 64'(resp_valid), 64'd1);
      chk("hold resp_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
      chk("hold req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    ack();
    chk("post ack req_ready", 64'(req_ready), 64'd1);

    // Back-to-back loads, each issued right after the previous response handshake.
    send(32'h3003, 3'b011, 1'b0, 64'h0);
    wait_resp(1, lat);
    chk("b2b0 latency", 64'(lat), 64'd3);
    chk("b2b0 rdata", resp_rdata, 64'h80);
    ack();
    chk("b2b req_ready", 64'(req_ready), 64'd1);
    send(32'h3003, 3'b111, 1'b0, 64'h0);
    wait_resp(1, lat);
    chk("b2b1 latency", 64'(lat), 64'd3);
    chk("b2b1 rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    ack();

    // Reset while waiting for beat 0 of a load; the late completion must be ignored.
    rv_block = 1'b1;
    beats.delete();
`ifdef LSU_MISALIGN_EN
    send(32'h1006, 3'b101, 1'b0, 64'h0);
`else
    send(32'h1004, 3'b101, 1'b0, 64'h0);
`endif
    @(negedge clk);
    chk("rst granted beats", 64'(beats.size()), 64'd1);
    chk("rst in WAIT mem_req", 64'(mem_req), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst resp_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rv_block = 1'b0;
    req_seen = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) seen++;
    end
    chk("rst stray response", 64'(seen), 64'd0);
    chk("rst stray beats", 64'(req_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
